nf10_upb_aurora_pause_ctrl: RTL and testbench
=============================================

Name: nf10_upb_aurora_pause_ctrl

Overview:
Link-level flow-control controller for the Aurora interconnect endpoint. It watches the receive-side FIFO fill level and sequences pause and resume requests toward the Aurora TX path, which carries them in the control lane. It holds each request until the TX path acknowledges that the request has gone onto the link. While paused, it periodically refreshes the pause request, and it re-synchronises whenever the channel drops.

Parameters:
C_FILL_WIDTH, 10, width of rx_fill_level in entries
C_PAUSE_THRESHOLD, 768, fill level (>=) that triggers a pause
C_RESUME_THRESHOLD, 256, fill level (<=) that permits resume; must be < C_PAUSE_THRESHOLD
C_REFRESH_CYCLES, 4096, cycles in PAUSED before the pause request is re-sent; must be >= 1
C_SETTLE_CYCLES, 16, consecutive channel_up cycles required before leaving LINK_DOWN; must be >= 1

Ports:
axi_aclk  in  1  clock; same domain as the Aurora user clock
axi_reset  in  1  synchronous reset, active-high
channel_up  in  1  Aurora channel status
rx_fill_level  in  C_FILL_WIDTH  occupancy of the receive FIFO
force_pause  in  1  management override; holds the remote side paused
pause_ack  in  1  one-cycle pulse: TX path has sent the pending flow-control word
flow_control_pause_req  out  1  request pending; held until pause_ack
flow_control_pause_val  out  1  1 = pause, 0 = resume; valid while req = 1
remote_paused  out  1  last acknowledged value sent to the peer
pause_count  out  16  saturating count of pause episodes

Behaviour:
- Clock and reset: one clock, axi_aclk. Reset is synchronous and active-high: axi_reset is sampled on the rising edge of axi_aclk.
- All outputs are registered.
- Reset values: state = LINK_DOWN, req = 0, val = 0, remote_paused = 0, pause_count = 0, settle counter = 0, refresh counter = 0.
- Latency: a condition sampled in cycle N is visible on the outputs in cycle N+1.
- Let pause_cond = (rx_fill_level >= C_PAUSE_THRESHOLD) || force_pause.
- Let resume_cond = (rx_fill_level <= C_RESUME_THRESHOLD) && !force_pause.
- FSM states: LINK_DOWN, RUNNING, SEND_PAUSE, PAUSED, SEND_RESUME.
- LINK_DOWN: req = 0. The settle counter increments while channel_up = 1 and clears when channel_up = 0. When it reaches C_SETTLE_CYCLES-1 with channel_up = 1, go to RUNNING. The peer clears its own stop flag on channel loss, so RUNNING is the consistent post-link state.
- RUNNING: req = 0. If pause_cond, go to SEND_PAUSE and increment pause_count (saturate at 0xFFFF).
- SEND_PAUSE: req = 1, val = 1. On pause_ack, go to PAUSED, set remote_paused = 1, and load the refresh counter with C_REFRESH_CYCLES-1.
- PAUSED: req = 0.
  - If resume_cond, go to SEND_RESUME.
  - Otherwise, if the refresh counter = 0, go to SEND_PAUSE (a refresh; pause_count is not incremented).
  - Otherwise, decrement the refresh counter.
  - If resume_cond and refresh expiry coincide, resume wins.
- SEND_RESUME: req = 1, val = 0. On pause_ack, go to RUNNING and set remote_paused = 0. If pause_cond becomes true while waiting, the request is not withdrawn or changed; the FSM finishes the resume, then re-pauses from RUNNING.
- Request stability: while req = 1, req and val stay constant until pause_ack or channel loss.
- pause_ack while req = 0 is ignored.
- Channel loss: channel_up = 0 in any state other than LINK_DOWN sends the FSM to LINK_DOWN on the next edge, with req = 0, remote_paused = 0 and the settle counter cleared. This overrides a simultaneous pause_ack.
- Thresholds: comparisons are unsigned at C_FILL_WIDTH. Fill values between the two thresholds hold the current state (hysteresis).
- Reset mid-request: req drops in the cycle after reset is sampled. No acknowledgement is awaited.

Decomposition:
- Shared package: the FSM state encoding (5 states, 3 bits) and the pause_count width constant.
- No sub-module. The refresh counter, settle counter and FSM are all inline, about 150 lines of RTL.

Test Plan:
- Link bring-up: hold channel_up = 1 from cycle 0 → RUNNING entered after exactly 16 cycles; req stays 0 throughout.
- Pause and resume: ramp fill 0 → 768 → req = 1, val = 1 the next cycle. Ack at +5 → remote_paused = 1, req = 0, pause_count = 1. Fill 300 → no change. Fill 256 → req = 1, val = 0; ack → remote_paused = 0.
- Refresh: with C_REFRESH_CYCLES = 8, hold fill 800 after the pause ack → req = 1, val = 1 reasserted every 8 cycles plus the ack delay; pause_count stays at 1.
- Stability: in SEND_RESUME, raise fill to 900 and delay ack 20 cycles → val stays 0 for all 20 cycles. After the ack, RUNNING lasts one cycle, then SEND_PAUSE, and pause_count increments.
- Channel loss: drop channel_up in the same cycle as pause_ack during SEND_PAUSE → next cycle LINK_DOWN, req = 0, remote_paused = 0. A later 16-cycle settle returns the FSM to RUNNING.
- force_pause with fill = 0: pause is sent. Releasing force_pause → resume is sent. Stray pause_ack pulses in RUNNING → no state change.

Source files
------------

// File: rtl/nf10_upb_aurora_pause_ctrl_pkg.sv
// Shared definitions for the Aurora link-level pause controller:
// FSM state encoding, pause episode counter width and a saturating increment.
package nf10_upb_aurora_pause_ctrl_pkg;

    localparam int unsigned PAUSE_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_LINK_DOWN   = 3'd0,
        ST_RUNNING     = 3'd1,
        ST_SEND_PAUSE  = 3'd2,
        ST_PAUSED      = 3'd3,
        ST_SEND_RESUME = 3'd4
    } pause_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PAUSE_CNT_W-1:0] sat_inc(input logic [PAUSE_CNT_W-1:0] v);
        return (&v) ? v : v + PAUSE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/nf10_upb_aurora_pause_ctrl.sv
// Link-level flow-control controller for the Aurora endpoint.
// Watches the RX FIFO fill level and sequences pause/resume requests to the
// Aurora TX path, holding each request until the TX path acknowledges it.
// While paused the pause request is periodically re-sent; a dropped channel
// forces a re-settle before normal operation resumes.
//
// Ports:
//   axi_aclk               clock (Aurora user clock domain)
//   axi_reset              synchronous active-high reset
//   channel_up             Aurora channel status
//   rx_fill_level          RX FIFO occupancy
//   force_pause            management override, holds the peer paused
//   pause_ack              one-cycle pulse, pending flow-control word sent
//   flow_control_pause_req request pending (held until pause_ack)
//   flow_control_pause_val 1 = pause, 0 = resume; valid while req = 1
//   remote_paused          last acknowledged value sent to the peer
//   pause_count            saturating count of pause episodes
module nf10_upb_aurora_pause_ctrl
    import nf10_upb_aurora_pause_ctrl_pkg::*;
#(
    parameter int unsigned C_FILL_WIDTH       = 10,
    parameter int unsigned C_PAUSE_THRESHOLD  = 768,
    parameter int unsigned C_RESUME_THRESHOLD = 256,
    parameter int unsigned C_REFRESH_CYCLES   = 4096,
    parameter int unsigned C_SETTLE_CYCLES    = 16
) (
    input  logic                    axi_aclk,
    input  logic                    axi_reset,
    input  logic                    channel_up,
    input  logic [C_FILL_WIDTH-1:0] rx_fill_level,
    input  logic                    force_pause,
    input  logic                    pause_ack,
    output logic                    flow_control_pause_req,
    output logic                    flow_control_pause_val,
    output logic                    remote_paused,
    output logic [PAUSE_CNT_W-1:0]  pause_count
);

    localparam int unsigned LP_REF_W = (C_REFRESH_CYCLES > 1) ? $clog2(C_REFRESH_CYCLES) : 1;
    localparam int unsigned LP_SET_W = (C_SETTLE_CYCLES > 1) ? $clog2(C_SETTLE_CYCLES) : 1;

    localparam logic [C_FILL_WIDTH-1:0] LP_PAUSE_TH  = C_FILL_WIDTH'(C_PAUSE_THRESHOLD);
    localparam logic [C_FILL_WIDTH-1:0] LP_RESUME_TH = C_FILL_WIDTH'(C_RESUME_THRESHOLD);
    localparam logic [LP_REF_W-1:0]     LP_REF_LOAD  = LP_REF_W'(C_REFRESH_CYCLES - 1);
    localparam logic [LP_SET_W-1:0]     LP_SET_LAST  = LP_SET_W'(C_SETTLE_CYCLES - 1);

    pause_state_e            r_state;
    pause_state_e            w_state_nxt;
    logic [LP_SET_W-1:0]     r_settle;
    logic [LP_SET_W-1:0]     w_settle_nxt;
    logic [LP_REF_W-1:0]     r_refresh;
    logic [LP_REF_W-1:0]     w_refresh_nxt;
    logic                    r_req;
    logic                    w_req_nxt;
    logic                    r_val;
    logic                    w_val_nxt;
    logic                    r_remote_paused;
    logic                    w_remote_paused_nxt;
    logic [PAUSE_CNT_W-1:0]  r_pause_count;
    logic [PAUSE_CNT_W-1:0]  w_pause_count_nxt;

    logic                    w_pause_cond;
    logic                    w_resume_cond;

    // Hysteresis conditions: fills between the thresholds satisfy neither.
    assign w_pause_cond  = (rx_fill_level >= LP_PAUSE_TH) || force_pause;
    assign w_resume_cond = (rx_fill_level <= LP_RESUME_TH) && !force_pause;

    // State and registered outputs.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_state         <= ST_LINK_DOWN;
            r_settle        <= '0;
            r_refresh       <= '0;
            r_req           <= 1'b0;
            r_val           <= 1'b0;
            r_remote_paused <= 1'b0;
            r_pause_count   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_settle        <= w_settle_nxt;
            r_refresh       <= w_refresh_nxt;
            r_req           <= w_req_nxt;
            r_val           <= w_val_nxt;
            r_remote_paused <= w_remote_paused_nxt;
            r_pause_count   <= w_pause_count_nxt;
        end
    end

    // Next-state logic; channel loss takes priority over everything, including an ack.
    always_comb begin
        w_state_nxt         = r_state;
        w_settle_nxt        = r_settle;
        w_refresh_nxt       = r_refresh;
        w_remote_paused_nxt = r_remote_paused;
        w_pause_count_nxt   = r_pause_count;

        if ((r_state != ST_LINK_DOWN) && !channel_up) begin
            w_state_nxt         = ST_LINK_DOWN;
            w_settle_nxt        = '0;
            w_remote_paused_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_LINK_DOWN: begin
                    if (!channel_up) begin
                        w_settle_nxt = '0;
                    end else if (r_settle == LP_SET_LAST) begin
                        w_settle_nxt = '0;
                        w_state_nxt  = ST_RUNNING;
                    end else begin
                        w_settle_nxt = r_settle + LP_SET_W'(1);
                    end
                end
                ST_RUNNING: begin
                    if (w_pause_cond) begin
                        w_state_nxt       = ST_SEND_PAUSE;
                        w_pause_count_nxt = sat_inc(r_pause_count);
                    end
                end
                ST_SEND_PAUSE: begin
                    if (pause_ack) begin
                        w_state_nxt         = ST_PAUSED;
                        w_remote_paused_nxt = 1'b1;
                        w_refresh_nxt       = LP_REF_LOAD;
                    end
                end
                ST_PAUSED: begin
                    if (w_resume_cond) begin
                        w_state_nxt = ST_SEND_RESUME;
                    end else if (r_refresh == '0) begin
                        w_state_nxt = ST_SEND_PAUSE;
                    end else begin
                        w_refresh_nxt = r_refresh - LP_REF_W'(1);
                    end
                end
                ST_SEND_RESUME: begin
                    // A pause condition here is deliberately ignored: the
                    // in-flight resume completes and RUNNING re-pauses.
                    if (pause_ack) begin
                        w_state_nxt         = ST_RUNNING;
                        w_remote_paused_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt  = ST_LINK_DOWN;
                    w_settle_nxt = '0;
                end
            endcase
        end

        // Request outputs follow the state being entered, so they appear one cycle after sampling.
        w_req_nxt = (w_state_nxt == ST_SEND_PAUSE) || (w_state_nxt == ST_SEND_RESUME);
        w_val_nxt = (w_state_nxt == ST_SEND_PAUSE);
    end

    assign flow_control_pause_req = r_req;
    assign flow_control_pause_val = r_val;
    assign remote_paused          = r_remote_paused;
    assign pause_count            = r_pause_count;

endmodule

// File: tb/tb_nf10_upb_aurora_pause_ctrl.sv
// Self-checking bench for nf10_upb_aurora_pause_ctrl: directed scenarios with
// hand-computed expectations followed by randomized traffic, all compared
// every cycle against a behavioural model of the flow-control protocol.
module tb_nf10_upb_aurora_pause_ctrl;

    localparam int unsigned FW      = 10;
    localparam int unsigned P_TH    = 768;
    localparam int unsigned R_TH    = 256;
    localparam int unsigned REFRESH = 8;
    localparam int unsigned SETTLE  = 16;

    logic          axi_aclk = 1'b0;
    logic          axi_reset;
    logic          channel_up;
    logic [FW-1:0] rx_fill_level;
    logic          force_pause;
    logic          pause_ack;
    logic          req;
    logic          val;
    logic          rpaused;
    logic [15:0]   pcount;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: link flag, consecutive-up count, pending request
    // kind (0 none, 1 pause, 2 resume), peer view, episodes, paused-cycle budget.
    bit m_link    = 0;
    int m_upcnt   = 0;
    int m_pend    = 0;
    bit m_remote  = 0;
    int m_count   = 0;
    int m_budget  = 0;

    always #5 axi_aclk = ~axi_aclk;

    nf10_upb_aurora_pause_ctrl #(
        .C_FILL_WIDTH       (FW),
        .C_PAUSE_THRESHOLD  (P_TH),
        .C_RESUME_THRESHOLD (R_TH),
        .C_REFRESH_CYCLES   (REFRESH),
        .C_SETTLE_CYCLES    (SETTLE)
    ) dut (
        .axi_aclk               (axi_aclk),
        .axi_reset              (axi_reset),
        .channel_up             (channel_up),
        .rx_fill_level          (rx_fill_level),
        .force_pause            (force_pause),
        .pause_ack              (pause_ack),
        .flow_control_pause_req (req),
        .flow_control_pause_val (val),
        .remote_paused          (rpaused),
        .pause_count            (pcount)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        bit pc, rc;
        pc = (int'(rx_fill_level) >= P_TH) || force_pause;
        rc = (int'(rx_fill_level) <= R_TH) && !force_pause;
        if (axi_reset) begin
            m_link = 0; m_upcnt = 0; m_pend = 0; m_remote = 0; m_count = 0; m_budget = 0;
        end else if (m_link && !channel_up) begin
            m_link = 0; m_upcnt = 0; m_pend = 0; m_remote = 0;
        end else if (!m_link) begin
            if (channel_up) begin
                m_upcnt++;
                if (m_upcnt == SETTLE) begin m_link = 1; m_upcnt = 0; end
            end else m_upcnt = 0;
        end else if (m_pend != 0) begin
            if (pause_ack) begin
                if (m_pend == 1) begin m_remote = 1; m_budget = REFRESH; end
                else m_remote = 0;
                m_pend = 0;
            end
        end else if (!m_remote) begin
            if (pc) begin m_pend = 1; if (m_count < 65535) m_count++; end
        end else begin
            if (rc) m_pend = 2;
            else if (m_budget == 1) m_pend = 1;
            else m_budget--;
        end
    endtask

    // One clock: update the model, let the DUT clock, then compare on the falling edge.
    task automatic tick();
        model_step();
        @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("req", 32'(req), 32'(m_pend != 0));
        if (m_pend != 0) chk("val", 32'(val), 32'(m_pend == 1));
        chk("remote_paused", 32'(rpaused), 32'(m_remote));
        chk("pause_count", 32'(pcount), 32'(m_count));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        axi_reset = 1'b1; channel_up = 1'b0; rx_fill_level = '0;
        force_pause = 1'b0; pause_ack = 1'b0;
        ticks(3);
        chk("lit_reset_req", 32'(req), 0);
        chk("lit_reset_remote", 32'(rpaused), 0);
        chk("lit_reset_count", 32'(pcount), 0);

        // Bring-up with fill already at the pause threshold.
        axi_reset = 1'b0; channel_up = 1'b1; rx_fill_level = 10'd768;
        ticks(16);
        chk("lit_settle_req_low", 32'(req), 0);
        tick();
        chk("lit_pause_req", 32'(req), 1);
        chk("lit_pause_val", 32'(val), 1);
        ticks(4);
        pause_ack = 1'b1; tick(); pause_ack = 1'b0;
        chk("lit_paused_remote", 32'(rpaused), 1);
        chk("lit_paused_req", 32'(req), 0);
        chk("lit_paused_count", 32'(pcount), 1);

        // Hysteresis then resume at exactly the resume threshold.
        rx_fill_level = 10'd300; ticks(5);
        chk("lit_hyst_req", 32'(req), 0);
        rx_fill_level = 10'd256; tick();
        chk("lit_resume_req", 32'(req), 1);
        chk("lit_resume_val", 32'(val), 0);
        pause_ack = 1'b1; tick(); pause_ack = 1'b0;
        chk("lit_resumed_remote", 32'(rpaused), 0);

        // Refresh while held above threshold.
        rx_fill_level = 10'd800; tick();
        pause_ack = 1'b1; tick(); pause_ack = 1'b0;
        ticks(7);
        chk("lit_refresh_not_yet", 32'(req), 0);
        tick();
        chk("lit_refresh_req", 32'(req), 1);
        chk("lit_refresh_val", 32'(val), 1);
        chk("lit_refresh_count", 32'(pcount), 2);
        pause_ack = 1'b1; tick(); pause_ack = 1'b0;

        // Resume must not be withdrawn when fill jumps back up.
        rx_fill_level = 10'd100; tick();
        rx_fill_level = 10'd900; ticks(20);
        chk("lit_stable_val", 32'(val), 0);
        pause_ack = 1'b1; tick(); pause_ack = 1'b0;
        chk("lit_stable_running_req", 32'(req), 0);
        tick();
        chk("lit_repause_val", 32'(val), 1);
        chk("lit_repause_count", 32'(pcount), 3);

        // Channel loss coinciding with the ack.
        pause_ack = 1'b1; channel_up = 1'b0; tick(); pause_ack = 1'b0;
        chk("lit_loss_req", 32'(req), 0);
        chk("lit_loss_remote", 32'(rpaused), 0);
        channel_up = 1'b1; rx_fill_level = '0; ticks(16);

        // Forced pause with empty FIFO, release, stray acks.
        force_pause = 1'b1; tick();
        chk("lit_force_req", 32'(req), 1);
        chk("lit_force_count", 32'(pcount), 4);
        pause_ack = 1'b1; tick(); pause_ack = 1'b0;
        force_pause = 1'b0; tick();
        chk("lit_release_val", 32'(val), 0);
        pause_ack = 1'b1; ticks(4); pause_ack = 1'b0;
        chk("lit_stray_req", 32'(req), 0);
        chk("lit_stray_remote", 32'(rpaused), 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            axi_reset   = ($urandom_range(0, 299) == 0);
            channel_up  = ($urandom_range(0, 79) != 0);
            force_pause = ($urandom_range(0, 15) == 0);
            pause_ack   = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: rx_fill_level = FW'($urandom_range(0, 256));
                1: rx_fill_level = FW'($urandom_range(257, 767));
                2: rx_fill_level = FW'($urandom_range(768, 1023));
                3: rx_fill_level = FW'($urandom_range(255, 257));
                4: rx_fill_level = FW'($urandom_range(767, 769));
                default: rx_fill_level = rx_fill_level;
            endcase
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
